// File: rtl/sc_trojan_monitor_pkg.sv
// Shared types and helpers for the stochastic-bitstream Trojan monitor.
package sc_mon_pkg;

    // Monitor control states.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_REPORT = 2'd2
    } state_e;

    // "No mismatch seen" sentinel: all ones in a cnt_w-bit field.
    function automatic int unsigned no_mm(input int cnt_w);
        if (cnt_w >= 32) begin
            return 32'hFFFF_FFFF;
        end
        return (32'd1 << cnt_w) - 32'd1;
    endfunction

    // Every index 0..bit_length-1 and every count up to bit_length must fit
    // in cnt_w bits without colliding with the all-ones sentinel.
    function automatic bit params_legal(input int bit_length, input int cnt_w);
        return (cnt_w > 0) && (cnt_w < 32) && (bit_length > 0) &&
               ($clog2(bit_length + 1) <= cnt_w);
    endfunction

endpackage

// File: rtl/sc_trojan_monitor_if.sv
// Bit-stream input and result bundle between a stream source and the monitor.
//
// Handshake: bit_valid qualifies bit_ref/bit_obs for one cycle. There is no
// ready; the monitor consumes every valid bit while busy=1 and ignores
// bit_valid otherwise. start is a single-cycle request that is always
// accepted. done is a one-cycle pulse during which (and after which, until
// the next done or reset) the result fields describe the finished stream.
interface sc_trojan_monitor_if #(
    parameter int CNT_W = 8
) ();
    import sc_mon_pkg::*;

    logic             start;
    logic             bit_valid;
    logic             bit_ref;
    logic             bit_obs;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] ones_ref;
    logic [CNT_W-1:0] ones_obs;
    logic [CNT_W-1:0] mismatches;
    logic [CNT_W-1:0] first_mm_idx;
    logic [CNT_W-1:0] period;
    logic             periodic;
    logic             alarm;
    state_e           dbg_state;

    // Stream source side.
    modport master (
        output start, bit_valid, bit_ref, bit_obs,
        input  busy, done, ones_ref, ones_obs, mismatches, first_mm_idx,
               period, periodic, alarm, dbg_state
    );

    // Monitor side.
    modport slave (
        input  start, bit_valid, bit_ref, bit_obs,
        output busy, done, ones_ref, ones_obs, mismatches, first_mm_idx,
               period, periodic, alarm, dbg_state
    );

endinterface

// File: rtl/sc_trojan_monitor_gap_tracker.sv
// Tracks first mismatch index and spacing between mismatches; flags a stream
// as periodic once enough consecutive equal gaps are seen. Outputs show the
// state including the current cycle's strobe so the parent can capture the
// final result on the same edge as the last bit.
module sc_gap_tracker
    import sc_mon_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter int PERIOD_MIN = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             mm_stb_i,
    input  logic [CNT_W-1:0] idx_i,
    output logic [CNT_W-1:0] first_mm_o,
    output logic [CNT_W-1:0] period_o,
    output logic             periodic_o
);

    localparam logic [CNT_W-1:0] NO_MM_V    = CNT_W'(no_mm(CNT_W));
    localparam logic [CNT_W-1:0] STREAK_MIN = CNT_W'(PERIOD_MIN);

    logic             have_mm_q,  have_mm_d;
    logic [CNT_W-1:0] first_mm_q, first_mm_d;
    logic [CNT_W-1:0] last_mm_q,  last_mm_d;
    logic [CNT_W-1:0] gap_q,      gap_d;
    logic [CNT_W-1:0] streak_q,   streak_d;
    logic             periodic_q, periodic_d;
    logic [CNT_W-1:0] gap_now;

    assign gap_now = idx_i - last_mm_q;

    // Next-state: clear on a new stream, otherwise fold in one mismatch.
    always_comb begin
        have_mm_d  = have_mm_q;
        first_mm_d = first_mm_q;
        last_mm_d  = last_mm_q;
        gap_d      = gap_q;
        streak_d   = streak_q;
        periodic_d = periodic_q;
        if (clear_i) begin
            have_mm_d  = 1'b0;
            first_mm_d = NO_MM_V;
            last_mm_d  = '0;
            gap_d      = '0;
            streak_d   = '0;
            periodic_d = 1'b0;
        end else if (mm_stb_i) begin
            if (!have_mm_q) begin
                have_mm_d  = 1'b1;
                first_mm_d = idx_i;
            end else begin
                gap_d = gap_now;
                if (gap_now == gap_q) begin
                    streak_d = (streak_q == '1) ? streak_q : streak_q + CNT_W'(1);
                end else begin
                    streak_d = CNT_W'(1);
                end
                if (streak_d >= STREAK_MIN) begin
                    periodic_d = 1'b1;
                end
            end
            last_mm_d = idx_i;
        end
    end

    // Tracker registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            have_mm_q  <= 1'b0;
            first_mm_q <= NO_MM_V;
            last_mm_q  <= '0;
            gap_q      <= '0;
            streak_q   <= '0;
            periodic_q <= 1'b0;
        end else begin
            have_mm_q  <= have_mm_d;
            first_mm_q <= first_mm_d;
            last_mm_q  <= last_mm_d;
            gap_q      <= gap_d;
            streak_q   <= streak_d;
            periodic_q <= periodic_d;
        end
    end

    assign first_mm_o = first_mm_d;
    assign period_o   = gap_d;
    assign periodic_o = periodic_d;

endmodule

// File: rtl/sc_trojan_monitor.sv
// Run-time monitor comparing a clean and an observed stochastic bitstream:
// ones counts, mismatch count, first mismatch, gap periodicity and alarm,
// reported once per stream with a one-cycle done pulse.
module sc_trojan_monitor
    import sc_mon_pkg::*;
#(
    parameter int BIT_LENGTH      = 128,
    parameter int CNT_W           = 8,
    parameter int MISMATCH_THRESH = 4,
    parameter int PERIOD_MIN      = 3
) (
    input logic                clk,
    input logic                rst_n,
    sc_trojan_monitor_if.slave mon_if
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BIT_LENGTH - 1);
    localparam logic [CNT_W-1:0] THRESH   = CNT_W'(MISMATCH_THRESH);
    localparam logic [CNT_W-1:0] NO_MM_V  = CNT_W'(no_mm(CNT_W));

    if (!params_legal(BIT_LENGTH, CNT_W)) begin : g_bad_params
        $error("sc_trojan_monitor: CNT_W too narrow for BIT_LENGTH");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    state_e           state_q, state_d;
    logic             clear;
    logic             sample;
    logic             last_bit;
    logic             mm_stb;
    logic [CNT_W-1:0] idx_q,      idx_d;
    logic [CNT_W-1:0] ones_ref_q, ones_ref_d;
    logic [CNT_W-1:0] ones_obs_q, ones_obs_d;
    logic [CNT_W-1:0] mm_cnt_q,   mm_cnt_d;

    logic [CNT_W-1:0] trk_first_mm;
    logic [CNT_W-1:0] trk_period;
    logic             trk_periodic;

    logic [CNT_W-1:0] res_ones_ref_q;
    logic [CNT_W-1:0] res_ones_obs_q;
    logic [CNT_W-1:0] res_mm_q;
    logic [CNT_W-1:0] res_first_q;
    logic [CNT_W-1:0] res_period_q;
    logic             res_periodic_q;
    logic             res_alarm_q;

    // Control: start wins in every state; a bit is taken only in RUN.
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mon_if.start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end
            end
            ST_RUN: begin
                if (mon_if.start) begin
                    clear = 1'b1;
                end else if (mon_if.bit_valid) begin
                    sample = 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_REPORT;
                    end
                end
            end
            ST_REPORT: begin
                if (mon_if.start) begin
                    state_d = ST_RUN;
                    clear   = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign last_bit = sample && (idx_q == LAST_IDX);
    assign mm_stb   = sample && (mon_if.bit_ref != mon_if.bit_obs);

    // Accumulator next-state: saturating counts and the bit index.
    always_comb begin
        idx_d      = idx_q;
        ones_ref_d = ones_ref_q;
        ones_obs_d = ones_obs_q;
        mm_cnt_d   = mm_cnt_q;
        if (clear) begin
            idx_d      = '0;
            ones_ref_d = '0;
            ones_obs_d = '0;
            mm_cnt_d   = '0;
        end else if (sample) begin
            if (mon_if.bit_ref) begin
                ones_ref_d = sat_inc(ones_ref_q);
            end
            if (mon_if.bit_obs) begin
                ones_obs_d = sat_inc(ones_obs_q);
            end
            if (mm_stb) begin
                mm_cnt_d = sat_inc(mm_cnt_q);
            end
            if (!last_bit) begin
                idx_d = sat_inc(idx_q);
            end
        end
    end

    // State and accumulator registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            ones_ref_q <= '0;
            ones_obs_q <= '0;
            mm_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ones_ref_q <= ones_ref_d;
            ones_obs_q <= ones_obs_d;
            mm_cnt_q   <= mm_cnt_d;
        end
    end

    sc_gap_tracker #(
        .CNT_W      (CNT_W),
        .PERIOD_MIN (PERIOD_MIN)
    ) u_gap (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .mm_stb_i   (mm_stb),
        .idx_i      (idx_q),
        .first_mm_o (trk_first_mm),
        .period_o   (trk_period),
        .periodic_o (trk_periodic)
    );

    // Result registers: loaded on the edge that enters REPORT, held otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_ones_ref_q <= '0;
            res_ones_obs_q <= '0;
            res_mm_q       <= '0;
            res_first_q    <= NO_MM_V;
            res_period_q   <= '0;
            res_periodic_q <= 1'b0;
            res_alarm_q    <= 1'b0;
        end else if (last_bit) begin
            res_ones_ref_q <= ones_ref_d;
            res_ones_obs_q <= ones_obs_d;
            res_mm_q       <= mm_cnt_d;
            res_first_q    <= trk_first_mm;
            res_period_q   <= trk_period;
            res_periodic_q <= trk_periodic;
            res_alarm_q    <= (mm_cnt_d >= THRESH) || trk_periodic;
        end
    end

    assign mon_if.busy         = (state_q == ST_RUN);
    assign mon_if.done         = (state_q == ST_REPORT);
    assign mon_if.dbg_state    = state_q;
    assign mon_if.ones_ref     = res_ones_ref_q;
    assign mon_if.ones_obs     = res_ones_obs_q;
    assign mon_if.mismatches   = res_mm_q;
    assign mon_if.first_mm_idx = res_first_q;
    assign mon_if.period       = res_period_q;
    assign mon_if.periodic     = res_periodic_q;
    assign mon_if.alarm        = res_alarm_q;

endmodule

// File: tb/tb_sc_trojan_monitor.sv
// Bench for sc_trojan_monitor: directed streams, a stream-level reference
// model checked every cycle, and literal expectations per scenario.
module tb_sc_trojan_monitor;
    import sc_mon_pkg::*;

    localparam int BL = 128;
    localparam int CW = 8;
    localparam int TH = 4;
    localparam int PM = 3;
    localparam int NO_MM_EXP = (1 << CW) - 1;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sc_trojan_monitor_if #(.CNT_W(CW)) mon_if ();

    sc_trojan_monitor #(
        .BIT_LENGTH      (BL),
        .CNT_W           (CW),
        .MISMATCH_THRESH (TH),
        .PERIOD_MIN      (PM)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .mon_if (mon_if)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_n      = 0;
    bit m_ref [BL];
    bit m_obs [BL];
    int e_ones_ref, e_ones_obs, e_mm, e_first, e_period;
    bit e_periodic, e_alarm;
    int cyc = 0, start_cyc = 0, done_cyc = 0, done_cnt = 0;

    task automatic model_reset();
        e_ones_ref = 0;
        e_ones_obs = 0;
        e_mm       = 0;
        e_first    = NO_MM_EXP;
        e_period   = 0;
        e_periodic = 1'b0;
        e_alarm    = 1'b0;
    endtask

    // Results of a whole stream from its recorded bits.
    task automatic model_report();
        int q[$];
        int ro, oo, run, prev_g, g;
        bit per;
        ro = 0; oo = 0; run = 0; prev_g = 0; per = 1'b0;
        for (int i = 0; i < BL; i++) begin
            ro += int'(m_ref[i]);
            oo += int'(m_obs[i]);
            if (m_ref[i] != m_obs[i]) q.push_back(i);
        end
        for (int i = 1; i < q.size(); i++) begin
            g      = q[i] - q[i-1];
            run    = (i > 1 && g == prev_g) ? run + 1 : 1;
            prev_g = g;
            if (run >= PM) per = 1'b1;
        end
        e_ones_ref = ro;
        e_ones_obs = oo;
        e_mm       = q.size();
        e_first    = (q.size() > 0) ? q[0] : NO_MM_EXP;
        e_period   = (q.size() >= 2) ? q[q.size()-1] - q[q.size()-2] : 0;
        e_periodic = per;
        e_alarm    = (q.size() >= TH) || per;
    endtask

    initial model_reset();

    // Per-cycle compare: advance the model on the inputs seen at this edge,
    // then compare every output.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (!rst_n) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            model_reset();
        end else begin
            m_done = 1'b0;
            if (mon_if.start) begin
                m_active  = 1'b1;
                m_n       = 0;
                start_cyc = cyc;
            end else if (m_active && mon_if.bit_valid) begin
                m_ref[m_n] = mon_if.bit_ref;
                m_obs[m_n] = mon_if.bit_obs;
                m_n++;
                if (m_n == BL) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    model_report();
                end
            end
        end
        chk("cyc_done",      mon_if.done,         m_done);
        chk("cyc_busy",      mon_if.busy,         m_active);
        chk("cyc_state_run", mon_if.dbg_state == ST_RUN, m_active);
        chk("cyc_ones_ref",  mon_if.ones_ref,     e_ones_ref);
        chk("cyc_ones_obs",  mon_if.ones_obs,     e_ones_obs);
        chk("cyc_mm",        mon_if.mismatches,   e_mm);
        chk("cyc_first",     mon_if.first_mm_idx, e_first);
        chk("cyc_period",    mon_if.period,       e_period);
        chk("cyc_periodic",  mon_if.periodic,     e_periodic);
        chk("cyc_alarm",     mon_if.alarm,        e_alarm);
        if (mon_if.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    bit pat_ref [BL];
    bit pat_obs [BL];

    // Reference alternates 1,0,...; the observed stream flips chosen indices.
    task automatic set_pat(input int kind);
        bit flip;
        for (int i = 0; i < BL; i++) begin
            pat_ref[i] = (i % 2 == 0);
            case (kind)
                1:       flip = (i % 8 == 0) && (i < 64);
                2:       flip = (i == 10) || (i == 90);
                3:       flip = (i == 5) || (i == 9) || (i == 20) || (i == 33);
                default: flip = 1'b0;
            endcase
            pat_obs[i] = pat_ref[i] ^ flip;
        end
    endtask

    // Called at a negedge; returns at the negedge after the last bit.
    task automatic drive_stream(input int n_bits, input int n_stalls, input bit valid_on_start);
        int stall_at [BL];
        foreach (stall_at[i]) stall_at[i] = 0;
        repeat (n_stalls) stall_at[$urandom_range(0, n_bits - 1)]++;
        mon_if.start     = 1'b1;
        mon_if.bit_valid = valid_on_start;
        mon_if.bit_ref   = 1'b1;
        mon_if.bit_obs   = 1'b0;
        @(negedge clk);
        mon_if.start = 1'b0;
        for (int i = 0; i < n_bits; i++) begin
            for (int s = 0; s < stall_at[i]; s++) begin
                mon_if.bit_valid = 1'b0;
                mon_if.bit_ref   = 1'($urandom_range(0, 1));
                mon_if.bit_obs   = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            mon_if.bit_valid = 1'b1;
            mon_if.bit_ref   = pat_ref[i];
            mon_if.bit_obs   = pat_obs[i];
            @(negedge clk);
        end
        mon_if.bit_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int c0, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (done_cnt != c0) break;
            @(negedge clk);
        end
        chk({name, "_done_count"}, done_cnt - c0, 1);
    endtask

    task automatic check_res(input string name, input int o_ref, input int o_obs, input int mm,
                             input int first, input int per, input bit prd, input bit alm);
        chk({name, "_ones_ref"}, mon_if.ones_ref,     o_ref);
        chk({name, "_ones_obs"}, mon_if.ones_obs,     o_obs);
        chk({name, "_mm"},       mon_if.mismatches,   mm);
        chk({name, "_first"},    mon_if.first_mm_idx, first);
        chk({name, "_period"},   mon_if.period,       per);
        chk({name, "_periodic"}, mon_if.periodic,     prd);
        chk({name, "_alarm"},    mon_if.alarm,        alm);
    endtask

    // done occupies the cycle that closes at the edge after it is first seen,
    // so start-edge to done-cycle distance is (done_cyc + 1) - start_cyc.
    function automatic int latency();
        return done_cyc + 1 - start_cyc;
    endfunction

    // ---------------- directed scenarios ----------------
    int c0;

    initial begin
        mon_if.start     = 1'b0;
        mon_if.bit_valid = 1'b0;
        mon_if.bit_ref   = 1'b0;
        mon_if.bit_obs   = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", mon_if.busy, 0);
        chk("reset_done", mon_if.done, 0);
        check_res("reset", 0, 0, 0, NO_MM_EXP, 0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Identical streams.
        set_pat(0);
        c0 = done_cnt;
        drive_stream(BL, 0, 1'b0);
        wait_done("t1", c0, 20);
        check_res("t1", 64, 64, 0, NO_MM_EXP, 0, 1'b0, 1'b0);
        chk("t1_latency", latency(), 129);

        // Inverting Trojan every 8 bits over the first 64 (start lands in REPORT).
        set_pat(1);
        c0 = done_cnt;
        drive_stream(BL, 0, 1'b0);
        wait_done("t2", c0, 20);
        check_res("t2", 64, 56, 8, 0, 8, 1'b1, 1'b1);
        chk("t2_latency", latency(), 129);

        // Two distant mismatches.
        set_pat(2);
        c0 = done_cnt;
        drive_stream(BL, 0, 1'b0);
        wait_done("t3", c0, 20);
        check_res("t3", 64, 62, 2, 10, 80, 1'b0, 1'b0);

        // Irregular gaps, alarm by threshold.
        set_pat(3);
        c0 = done_cnt;
        drive_stream(BL, 0, 1'b0);
        wait_done("t4", c0, 20);
        check_res("t4", 64, 66, 4, 5, 13, 1'b0, 1'b1);

        // Same stream with 10 stall cycles.
        set_pat(3);
        c0 = done_cnt;
        drive_stream(BL, 10, 1'b0);
        wait_done("t5", c0, 40);
        check_res("t5", 64, 66, 4, 5, 13, 1'b0, 1'b1);
        chk("t5_latency", latency(), 139);

        // Abort at bit 50 with a valid bit alongside the restart.
        @(negedge clk);
        set_pat(1);
        c0 = done_cnt;
        drive_stream(50, 0, 1'b0);
        chk("t6_no_early_done", done_cnt - c0, 0);
        set_pat(2);
        drive_stream(BL, 0, 1'b1);
        wait_done("t6", c0, 20);
        check_res("t6", 64, 62, 2, 10, 80, 1'b0, 1'b0);
        chk("t6_latency", latency(), 129);

        // Reset at bit 70; later valid bits arrive while idle.
        @(negedge clk);
        set_pat(1);
        c0 = done_cnt;
        drive_stream(70, 0, 1'b0);
        rst_n            = 1'b0;
        mon_if.bit_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t7_busy", mon_if.busy, 0);
        chk("t7_done", mon_if.done, 0);
        check_res("t7", 0, 0, 0, NO_MM_EXP, 0, 1'b0, 1'b0);
        for (int i = 70; i < BL; i++) begin
            mon_if.bit_valid = 1'b1;
            mon_if.bit_ref   = pat_ref[i];
            mon_if.bit_obs   = pat_obs[i];
            @(negedge clk);
        end
        mon_if.bit_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("t7_no_done", done_cnt - c0, 0);
        chk("t7_idle_busy", mon_if.busy, 0);
        chk("t7_idle_mm", mon_if.mismatches, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop if the scenario sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
